// File: rtl/data_mem_block_pkg.sv
// Shared definitions for the data memory and the cache that talks to it.
//   BLOCK_WIDTH     : bits per memory block
//   ADDR_WIDTH      : block address width ({tag,index})
//   CNT_WIDTH       : latency counter width (covers LATENCY 1..15)
//   DEFAULT_LATENCY : default access latency in clock cycles
//   ST_IDLE/ST_BUSY/ST_ACK : memory handshake state encoding
package data_mem_block_pkg;

  localparam int unsigned BLOCK_WIDTH     = 32;
  localparam int unsigned ADDR_WIDTH      = 6;
  localparam int unsigned CNT_WIDTH       = 4;
  localparam int unsigned DEFAULT_LATENCY = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_ACK  = 2'd2;

endpackage

// File: rtl/data_mem_block_mem_block_array.sv
// Block storage for the data memory: NUM_BLOCKS words of BLOCK_WIDTH bits.
// Byte k of a block sits at bits [8k+7:8k].
//   i_clk   : clock, all state on rising edge
//   i_rst   : synchronous active-high clear of storage and read register
//   i_we    : write i_wdata to block i_addr
//   i_re    : register block i_addr into o_rdata
//   i_addr  : block address, taken modulo NUM_BLOCKS
//   i_wdata : write data
//   o_rdata : registered read data, held until the next read
module mem_block_array
  import data_mem_block_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic                   i_re,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [BLOCK_WIDTH-1:0] i_wdata,
  output logic [BLOCK_WIDTH-1:0] o_rdata
);

  logic [BLOCK_WIDTH-1:0] r_mem [NUM_BLOCKS];
  logic [ADDR_WIDTH-1:0]  w_idx;

  assign w_idx = ADDR_WIDTH'(32'(i_addr) % NUM_BLOCKS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        r_mem[i] <= '0;
      end
      o_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[w_idx] <= i_wdata;
      end
      if (i_re) begin
        o_rdata <= r_mem[w_idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_block.sv
// Data memory with fixed access latency and an IDLE/BUSY/ACK handshake
// toward the cache.
//   CLK               : system clock, all state on rising edge
//   RESET             : synchronous active-high reset
//   mem_read          : block read request
//   mem_write         : block write request (wins if both are high)
//   mem_block_address : block address ({tag,index})
//   mem_WriteData     : block to write
//   mem_ReadData      : block read result, held until the next read commit
//   mem_busywait      : stall to the cache while a request is pending
module data_mem_block
  import data_mem_block_pkg::*;
#(
  parameter int unsigned LATENCY    = DEFAULT_LATENCY,
  parameter int unsigned NUM_BLOCKS = 64
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [ADDR_WIDTH-1:0]  mem_block_address,
  input  logic [BLOCK_WIDTH-1:0] mem_WriteData,
  output logic [BLOCK_WIDTH-1:0] mem_ReadData,
  output logic                   mem_busywait
);

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BLOCK_WIDTH-1:0] r_wdata;
  logic                   r_is_write;

  logic w_req;
  logic w_commit;

  assign w_req    = mem_read | mem_write;
  // The commit edge is the BUSY edge on which the counter has run out;
  // RESET on that edge wins because the array clears instead of writing.
  assign w_commit = (r_state == ST_BUSY) && (r_count == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr     <= mem_block_address;
            r_wdata    <= mem_WriteData;
            r_is_write <= mem_write;
            r_count    <= CNT_WIDTH'(LATENCY - 1);
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_state <= ST_ACK;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_busywait = 1'b0;
    case (r_state)
      ST_IDLE: mem_busywait = w_req;
      ST_BUSY: mem_busywait = 1'b1;
      default: mem_busywait = 1'b0;
    endcase
  end

  mem_block_array #(
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_array (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_we    (w_commit & r_is_write),
    .i_re    (w_commit & ~r_is_write),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (mem_ReadData)
  );

endmodule

// File: tb/tb_data_mem_block.sv
// Scoreboard bench for data_mem_block: the driver pushes the expected
// read-data and BUSY run length per transaction; the monitor pops on each
// ACK (busywait falling outside reset) and compares.
module tb_data_mem_block;

  logic        CLK;
  logic        RESET;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_block_address;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData;
  logic        mem_busywait;

  data_mem_block #(
    .LATENCY   (4),
    .NUM_BLOCKS(64)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_block_address(mem_block_address),
    .mem_WriteData    (mem_WriteData),
    .mem_ReadData     (mem_ReadData),
    .mem_busywait     (mem_busywait)
  );

  typedef struct {
    logic [31:0] data;
    int          run;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   issued   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  int   run        = 0;
  logic prev_busy  = 1'b0;
  logic prev_reset = 1'b1;
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (RESET) begin
      run = 0;
    end else if (mem_busywait) begin
      run++;
    end else if (prev_busy && !prev_reset) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: got rdata %h with empty queue", mem_ReadData);
      end else begin
        e = q.pop_front();
        check({e.name, "_rdata"}, mem_ReadData, e.data);
        check({e.name, "_busy_cycles"}, 32'(run), 32'(e.run));
      end
      done_cnt++;
      run = 0;
    end
    prev_busy  = mem_busywait;
    prev_reset = RESET;
  end

  // Issue one transaction; call just after a falling edge. Returns in the
  // ACK cycle, 1 time unit after its falling edge.
  task automatic op(input logic rd, input logic wr, input logic [5:0] a,
                    input logic [31:0] d, input logic [5:0] a_after,
                    input logic [31:0] exp, input int exp_run,
                    input bit from_ack, input string nm);
    exp_t e;
    bit   ok;
    e.data = exp;
    e.run  = exp_run;
    e.name = nm;
    q.push_back(e);
    issued++;
    mem_read          = rd;
    mem_write         = wr;
    mem_block_address = a;
    mem_WriteData     = d;
    #1;
    if (from_ack) begin
      check({nm, "_ack_ignores_req"}, 32'(mem_busywait), 32'd0);
      @(posedge CLK);
      #1;
      check({nm, "_idle_req_busy"}, 32'(mem_busywait), 32'd1);
      @(posedge CLK);
    end else begin
      check({nm, "_req_busy"}, 32'(mem_busywait), 32'd1);
      @(posedge CLK);
    end
    @(negedge CLK);
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_block_address = a_after;
    mem_WriteData     = ~d;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (done_cnt >= issued) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no ack expected ack within 60 cycles", nm);
    end
    #1;
    check({nm, "_ack_busy_low"}, 32'(mem_busywait), 32'd0);
  endtask

  task automatic idle();
    @(negedge CLK);
    #1;
    check("idle_busy_low", 32'(mem_busywait), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    RESET             = 1'b1;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_block_address = 6'h00;
    mem_WriteData     = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    check("reset_rdata", mem_ReadData, 32'h0);
    check("reset_busy", 32'(mem_busywait), 32'd0);
    RESET = 1'b0;
    idle();

    // Read after reset
    op(1, 0, 6'h05, 32'h0, 6'h06, 32'h0, 4, 0, "rd05_after_reset");
    idle();

    // Write then read
    op(0, 1, 6'h2A, 32'hDEADBEEF, 6'h15, 32'h0, 4, 0, "wr2A");
    idle();
    op(1, 0, 6'h2A, 32'h0, 6'h15, 32'hDEADBEEF, 4, 0, "rd2A");
    idle();

    // Write-back then fill, fill issued during ACK
    op(0, 1, 6'h31, 32'h31313131, 6'h24, 32'hDEADBEEF, 4, 0, "wr31");
    idle();
    op(0, 1, 6'h11, 32'h11223344, 6'h04, 32'hDEADBEEF, 4, 0, "wb11");
    op(1, 0, 6'h31, 32'h0, 6'h24, 32'h31313131, 5, 1, "fill31");
    idle();
    op(1, 0, 6'h11, 32'h0, 6'h04, 32'h11223344, 4, 0, "rd11");
    idle();

    // Read and write together act as a write
    op(1, 1, 6'h3F, 32'h0000A5A5, 6'h2A, 32'h11223344, 4, 0, "both3F");
    idle();
    op(1, 0, 6'h3F, 32'h0, 6'h2A, 32'h0000A5A5, 4, 0, "rd3F");
    idle();

    // Address change during BUSY must not affect the read
    op(0, 1, 6'h01, 32'h01010101, 6'h3E, 32'h0000A5A5, 4, 0, "wr01");
    idle();
    op(0, 1, 6'h02, 32'h02020202, 6'h3D, 32'h0000A5A5, 4, 0, "wr02");
    idle();
    op(1, 0, 6'h01, 32'h0, 6'h02, 32'h01010101, 4, 0, "rd01_addr_switch");
    idle();

    // Reset during BUSY drops the write
    mem_write         = 1'b1;
    mem_block_address = 6'h03;
    mem_WriteData     = 32'hCAFEF00D;
    #1;
    check("rst_op_req_busy", 32'(mem_busywait), 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_busy_follows_req", 32'(mem_busywait), 32'd1);
    check("rst_rdata_clear", mem_ReadData, 32'h0);
    @(negedge CLK);
    mem_write = 1'b0;
    RESET     = 1'b0;
    #1;
    check("rst_busy_no_req", 32'(mem_busywait), 32'd0);
    op(1, 0, 6'h03, 32'h0, 6'h00, 32'h0, 4, 0, "rd03_after_rst");
    idle();
    op(1, 0, 6'h2A, 32'h0, 6'h00, 32'h0, 4, 0, "rd2A_after_rst");
    idle();

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_block.md
DATA_MEM_BLOCK -- requirements
Module: data_mem_block

Interface
REQ-001 SHALL have parameter LATENCY, default 4, memory access latency in clock cycles (legal range 1..15).
REQ-002 SHALL have parameter NUM_BLOCKS, default 64, number of 32-bit blocks (256 bytes).
REQ-003 SHALL have port CLK input 1 system clock; one clock, all state on rising edge.
REQ-004 SHALL have port RESET input 1; reset is synchronous and active-high.
REQ-005 SHALL have port mem_read input 1 block read request from cache.
REQ-006 SHALL have port mem_write input 1 block write request from cache.
REQ-007 SHALL have port mem_block_address input 6 block address ({tag,index}).
REQ-008 SHALL have port mem_WriteData input 32 block to write; byte k at bits [8k+7:8k].
REQ-009 SHALL have port mem_ReadData output 32 block read result.
REQ-010 SHALL have port mem_busywait output 1 stall to cache; high while a request is pending.

Function
REQ-011 SHALL store NUM_BLOCKS x 32 bits; block b holds bytes 4b..4b+3, byte 4b+k at bits [8k+7:8k].
REQ-012 SHALL implement states IDLE, BUSY, ACK.
REQ-013 SHALL drive mem_busywait combinationally: 1 when (IDLE and (mem_read or mem_write)) or BUSY; 0 in ACK and in IDLE without request.
REQ-014 SHALL accept a request on the rising edge in IDLE with mem_read or mem_write high: latch address, write data and operation type; load counter with LATENCY-1; go to BUSY.
REQ-015 SHALL, on each BUSY edge with counter nonzero, decrement counter; with counter zero, commit the operation and go to ACK (commit on the LATENCY-th edge after acceptance).
REQ-016 SHALL, on read commit, register the addressed block into mem_ReadData; on write commit, write latched data to latched address; a write leaves mem_ReadData unchanged.
REQ-017 SHALL hold mem_ReadData stable from commit until the next read commit or reset.
REQ-018 SHALL go from ACK to IDLE on the next edge unconditionally; requests present during ACK are ignored and are accepted in IDLE on the following edge.
REQ-019 SHALL treat mem_read and mem_write both high at acceptance as a write; the read is dropped.
REQ-020 SHALL complete an accepted operation with latched values even if the requests or inputs change or drop during BUSY; no abort.
REQ-021 SHALL use only latched address/data at commit, never live inputs.
REQ-022 SHALL ignore out-of-range addresses modulo NUM_BLOCKS (6-bit address covers exactly 64).

Reset
REQ-023 SHALL, on a RESET-high edge: state IDLE, counter 0, mem_ReadData 32'h0, all storage 0, latched registers 0.
REQ-024 SHALL drop an operation in progress when RESET is asserted mid-BUSY; the write is not committed.
REQ-025 SHALL give RESET priority over request acceptance and commit on the same edge; mem_busywait follows REQ-013 from the reset state.

Structure
REQ-026 SHALL place the state encoding (IDLE=2'd0, BUSY=2'd1, ACK=2'd2), BLOCK_WIDTH=32, ADDR_WIDTH=6 and LATENCY default in a shared package used by the cache and memory.
REQ-027 SHALL place storage in one sub-module mem_block_array (synchronous write port, synchronous read into output register, synchronous clear); FSM and counter remain in data_mem_block.

Verification
REQ-028 Read after reset: LATENCY=4, mem_read=1 addr 6'h05 -> busywait high 5 cycles, ACK shows mem_ReadData=32'h0, busywait low 1 cycle.
REQ-029 Write then read: write addr 6'h2A data 32'hDEADBEEF, drop; read 6'h2A -> mem_ReadData=32'hDEADBEEF at commit edge (4th after acceptance).
REQ-030 Write-back then fill (cache miss dirty): write 6'h11 data 32'h11223344, on ACK switch to read 6'h31 -> read accepted the edge after ACK, write committed, read returns stored 6'h31 value.
REQ-031 Reset mid-operation: write 6'h03 data 32'hCAFEF00D, RESET at 2nd BUSY edge -> IDLE, busywait follows request; read 6'h03 returns 32'h0.
REQ-032 Simultaneous request: read=write=1 addr 6'h3F data 32'h0000A5A5 -> treated as write, mem_ReadData unchanged; later read 6'h3F returns 32'h0000A5A5.
REQ-033 Input change during BUSY: read 6'h01 accepted, address switched to 6'h02 at 1st BUSY edge -> returns block 6'h01.
